// File: rtl/rx_dac_output_stage.sv
// rx_dac_output_stage: per-channel soft mute/unmute ramp, power-of-two gain and saturation ahead of the DAC buses.
// Optional build macro RX_DAC_SAT_COUNT_EN adds per-channel saturation counters on sat_count.
module rx_dac_output_stage #(
  parameter int NUM_DAC        = 3,
  parameter int NUMBER_OF_LINE = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int RAMP_BITS      = 8
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUM_DAC*NUMBER_OF_LINE*DATA_WIDTH-1:0] din,
  input  logic                                         din_valid,
  input  logic [NUM_DAC-1:0]                           enable,
  input  logic [2*NUM_DAC-1:0]                         gain_shift,
  output logic [NUM_DAC*NUMBER_OF_LINE*DATA_WIDTH-1:0] dout,
  output logic                                         dout_valid,
  output logic [NUM_DAC-1:0]                           muted,
  output logic [NUM_DAC-1:0]                           ramp_busy
`ifdef RX_DAC_SAT_COUNT_EN
  ,
  output logic [16*NUM_DAC-1:0]                        sat_count
`endif
);

  localparam int LW = RAMP_BITS + 1;
  localparam int PW = DATA_WIDTH + RAMP_BITS + 2;
  localparam int QW = DATA_WIDTH + 2;
  localparam int SW = QW + 3;

  localparam logic [LW-1:0] LEVEL_MAX      = {1'b1, {RAMP_BITS{1'b0}}};
  localparam logic [LW-1:0] LEVEL_NEAR_MAX = {1'b0, {RAMP_BITS{1'b1}}};
  localparam logic [LW-1:0] LEVEL_ONE      = {{RAMP_BITS{1'b0}}, 1'b1};

  localparam logic signed [DATA_WIDTH-1:0] DW_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DW_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] ST_MUTED     = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  // din_valid only qualifies data (no backpressure): the pipeline always advances and
  // dout_valid is din_valid delayed through the same two stages as the samples.
  logic valid_s1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_s1   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      valid_s1   <= din_valid;
      dout_valid <= valid_s1;
    end
  end

  for (genvar c = 0; c < NUM_DAC; c++) begin : g_ch
    logic [1:0]    state, state_nx;
    logic [LW-1:0] level, level_nx;
    logic          muted_r, ramp_busy_r;
    logic [1:0]    gain_r;
    logic [NUMBER_OF_LINE-1:0] lane_sat;

    // While ramping, the live enable picks the direction, so a toggle reverses without a jump.
    always_comb begin
      state_nx = state;
      level_nx = level;
      case (state)
        ST_MUTED: begin
          level_nx = '0;
          if (enable[c]) state_nx = ST_RAMP_UP;
        end
        ST_ACTIVE: begin
          level_nx = LEVEL_MAX;
          if (!enable[c]) state_nx = ST_RAMP_DOWN;
        end
        default: begin
          if (enable[c]) begin
            if (level >= LEVEL_NEAR_MAX) begin
              state_nx = ST_ACTIVE;
              level_nx = LEVEL_MAX;
            end else begin
              state_nx = ST_RAMP_UP;
              level_nx = level + LEVEL_ONE;
            end
          end else begin
            if (level <= LEVEL_ONE) begin
              state_nx = ST_MUTED;
              level_nx = '0;
            end else begin
              state_nx = ST_RAMP_DOWN;
              level_nx = level - LEVEL_ONE;
            end
          end
        end
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state       <= ST_MUTED;
        level       <= '0;
        muted_r     <= 1'b1;
        ramp_busy_r <= 1'b0;
        gain_r      <= '0;
      end else begin
        state       <= state_nx;
        level       <= level_nx;
        muted_r     <= (state_nx == ST_MUTED);
        ramp_busy_r <= (state_nx == ST_RAMP_UP) || (state_nx == ST_RAMP_DOWN);
        gain_r      <= gain_shift[2*c +: 2];
      end
    end

    assign muted[c]     = muted_r;
    assign ramp_busy[c] = ramp_busy_r;

    for (genvar l = 0; l < NUMBER_OF_LINE; l++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] sample;
      logic signed [PW-1:0]         prod;
      logic signed [QW-1:0]         q;
      logic signed [SW-1:0]         scaled;
      logic                         clamp_hi, clamp_lo;
      logic signed [DATA_WIDTH-1:0] res, dout_r;

      assign sample = din[(c*NUMBER_OF_LINE+l)*DATA_WIDTH +: DATA_WIDTH];

      // Stage 2: drop the ramp fraction (floor), apply gain headroom, then clamp.
      assign q        = QW'(prod >>> RAMP_BITS);
      assign scaled   = SW'(q) <<< gain_r;
      assign clamp_hi = scaled > SW'(DW_MAX);
      assign clamp_lo = scaled < SW'(DW_MIN);
      assign res      = clamp_hi ? DW_MAX : (clamp_lo ? DW_MIN : scaled[DATA_WIDTH-1:0]);
      assign lane_sat[l] = clamp_hi | clamp_lo;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          prod   <= '0;
          dout_r <= '0;
        end else begin
          prod   <= PW'(sample) * PW'($signed({1'b0, level}));
          dout_r <= res;
        end
      end

      assign dout[(c*NUMBER_OF_LINE+l)*DATA_WIDTH +: DATA_WIDTH] = dout_r;
    end

`ifdef RX_DAC_SAT_COUNT_EN
    logic [15:0] sat_cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sat_cnt <= '0;
      end else if (valid_s1 && (|lane_sat) && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end

    assign sat_count[16*c +: 16] = sat_cnt;
`else
    logic unused_sat;
    assign unused_sat = |lane_sat;
`endif
  end

endmodule

// File: tb/tb_rx_dac_output_stage.sv
// Bench for rx_dac_output_stage: random and directed stimulus against an arithmetic reference model.
// Build with RX_DAC_SAT_COUNT_EN defined to also check sat_count.
`timescale 1ns/1ps
module tb_rx_dac_output_stage;
  localparam int NUM_DAC = 3;
  localparam int NL      = 8;
  localparam int DW      = 16;
  localparam int RB      = 4;
  localparam int MAX     = 1 << RB;
  localparam int BUS_W   = NUM_DAC * NL * DW;

  // ---------------- clock / reset ----------------
  logic                   clock = 1'b0;
  logic                   reset;
  logic [BUS_W-1:0]       din;
  logic                   din_valid;
  logic [NUM_DAC-1:0]     enable;
  logic [2*NUM_DAC-1:0]   gain_shift;
  logic [BUS_W-1:0]       dout;
  logic                   dout_valid;
  logic [NUM_DAC-1:0]     muted;
  logic [NUM_DAC-1:0]     ramp_busy;
`ifdef RX_DAC_SAT_COUNT_EN
  logic [16*NUM_DAC-1:0]  sat_count;
`endif

  always #5 clock = ~clock;

  rx_dac_output_stage #(
    .NUM_DAC(NUM_DAC), .NUMBER_OF_LINE(NL), .DATA_WIDTH(DW), .RAMP_BITS(RB)
  ) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .enable(enable), .gain_shift(gain_shift), .dout(dout), .dout_valid(dout_valid),
    .muted(muted), .ramp_busy(ramp_busy)
`ifdef RX_DAC_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  logic [BUS_W-1:0]   exp_q[$];
  logic               vld_q[$];
  logic [NUM_DAC-1:0] sat_q[$];
  int                 lvl[NUM_DAC];
  bit                 ramping[NUM_DAC];
  int                 exp_sat[NUM_DAC];

  task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Ideal arithmetic: sample * level / 2^RB rounded toward -inf, times 2^gain (unclamped).
  function automatic int ref_scaled(input logic [DW-1:0] s_bits, input int level, input int g);
    int s, p, q;
    s = int'($signed(s_bits));
    p = s * level;
    q = p / MAX;
    if (p < 0 && (p % MAX) != 0) q = q - 1;
    return q * (1 << g);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_DAC; c++) begin
      lvl[c] = 0;
      ramping[c] = 1'b0;
      exp_sat[c] = 0;
    end
    exp_q = {};
    vld_q = {};
    sat_q = {};
    exp_q.push_back('0);
    vld_q.push_back(1'b0);
    sat_q.push_back('0);
  endtask

  // One clock: predict from current inputs, advance the model, clock, compare.
  task automatic step();
    logic [BUS_W-1:0]   e;
    logic [NUM_DAC-1:0] sflag, exp_muted, exp_busy;
    logic [DW-1:0]      sv;
    logic               v;
    int                 sc;
    e = '0;
    sflag = '0;
    for (int c = 0; c < NUM_DAC; c++) begin
      for (int l = 0; l < NL; l++) begin
        sv = din[(c*NL+l)*DW +: DW];
        sc = ref_scaled(sv, lvl[c], int'(gain_shift[2*c +: 2]));
        if (sc > 32767)  begin sc = 32767;  sflag[c] = 1'b1; end
        if (sc < -32768) begin sc = -32768; sflag[c] = 1'b1; end
        e[(c*NL+l)*DW +: DW] = sc[DW-1:0];
      end
    end
    exp_q.push_back(e);
    vld_q.push_back(din_valid);
    sat_q.push_back(sflag);
    for (int c = 0; c < NUM_DAC; c++) begin
      if (!ramping[c]) begin
        if ((lvl[c] == 0 && enable[c]) || (lvl[c] == MAX && !enable[c])) ramping[c] = 1'b1;
      end else begin
        lvl[c] = lvl[c] + (enable[c] ? 1 : -1);
        if (lvl[c] > MAX) lvl[c] = MAX;
        if (lvl[c] < 0)   lvl[c] = 0;
        if (lvl[c] == MAX || lvl[c] == 0) ramping[c] = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    v = vld_q.pop_front();
    sflag = sat_q.pop_front();
    for (int c = 0; c < NUM_DAC; c++) begin
      if (v && sflag[c] && exp_sat[c] < 65535) exp_sat[c]++;
      exp_muted[c] = !ramping[c] && lvl[c] == 0;
      exp_busy[c]  = ramping[c];
    end
    check("dout", dout, e);
    check("dout_valid", BUS_W'(dout_valid), BUS_W'(v));
    check("muted", BUS_W'(muted), BUS_W'(exp_muted));
    check("ramp_busy", BUS_W'(ramp_busy), BUS_W'(exp_busy));
`ifdef RX_DAC_SAT_COUNT_EN
    for (int c = 0; c < NUM_DAC; c++)
      check("sat_count", BUS_W'(sat_count[16*c +: 16]), BUS_W'(exp_sat[c]));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_all(input logic [DW-1:0] s);
    for (int i = 0; i < NUM_DAC*NL; i++) din[i*DW +: DW] = s;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NUM_DAC*NL; i++) din[i*DW +: DW] = DW'($urandom);
  endtask

  // ---------------- directed + random sequences ----------------
  logic [DW-1:0] gin[3];
  logic [DW-1:0] gout[3];
  logic [5:0]    vin, vobs;
  int            busy_cnt;

  initial begin
    gin  = '{16'h1000, 16'hF000, 16'h0800};
    gout = '{16'h7FFF, 16'h8000, 16'h4000};
    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    enable = '0;
    gain_shift = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_dout", dout, '0);
    check("reset_dout_valid", BUS_W'(dout_valid), '0);
    check("reset_muted", BUS_W'(muted), BUS_W'(3'b111));
    check("reset_ramp_busy", BUS_W'(ramp_busy), '0);
    reset = 1'b0;

    // Ramp channel 0 up to level 7, then hit reset asynchronously.
    enable = 3'b001;
    drive_all(16'h1000);
    din_valid = 1'b1;
    for (int i = 0; i < 40 && lvl[0] != 7; i++) step();
    reset = 1'b1;
    #1;
    check("async_reset_dout", dout, '0);
    check("async_reset_muted", BUS_W'(muted), BUS_W'(3'b111));
    check("async_reset_busy", BUS_W'(ramp_busy), '0);
    check("async_reset_valid", BUS_W'(dout_valid), '0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Full unmute ramp from level 0.
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ramp_busy[0]) busy_cnt++;
    end
    check("ramp_busy_clocks", BUS_W'(busy_cnt), BUS_W'(16));
    check("ch0_active_muted", BUS_W'(muted), BUS_W'(3'b110));
    check("ch0_active_dout", BUS_W'(dout[DW-1:0]), BUS_W'(16'h1000));

    // Full mute ramp, then reverse direction at level 5.
    enable = 3'b000;
    for (int i = 0; i < 20; i++) step();
    enable = 3'b001;
    for (int i = 0; i < 10 && lvl[0] != 5; i++) step();
    enable = 3'b000;
    for (int i = 0; i < 8; i++) step();
    check("reversal_muted", BUS_W'(muted), BUS_W'(3'b111));

    // Gain saturation on all channels once active.
    enable = 3'b111;
    for (int i = 0; i < 20; i++) step();
    gain_shift = 6'b111111;
    for (int k = 0; k < 3; k++) begin
      drive_all(gin[k]);
      step();
      step();
      check("gain_sat_lane", BUS_W'(dout[DW-1:0]), BUS_W'(gout[k]));
      step();
    end

    // Valid pipeline pattern while clamping.
    drive_all(16'h1000);
    din_valid = 1'b0;
    step();
    step();
    vin = 6'b101100;
    for (int i = 0; i < 6; i++) begin
      vobs[5-i] = dout_valid;
      din_valid = vin[5-i];
      step();
    end
    check("valid_pipe", BUS_W'(vobs), BUS_W'(6'b001011));

    // Passthrough: active, unity gain, random samples.
    gain_shift = '0;
    for (int i = 0; i < 1000; i++) begin
      drive_random();
      din_valid = 1'($urandom_range(0, 1));
      step();
    end

    // Random enables and gains to exercise reversals and mixed levels.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      din_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) enable = NUM_DAC'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) gain_shift = (2*NUM_DAC)'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
